// File: rtl/ctrl_pkg.sv
// Shared opcode/func/ALU encodings, decode class and FSM state type for multicycle_control.
// HALT state exists only when CTRL_HALT_EN is defined.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_HALT  = 6'b111110;

    localparam logic [5:0] FN_ADD = 6'b110000;
    localparam logic [5:0] FN_SUB = 6'b110001;
    localparam logic [5:0] FN_AND = 6'b110010;
    localparam logic [5:0] FN_OR  = 6'b110011;
    localparam logic [5:0] FN_NOT = 6'b110100;
    localparam logic [5:0] FN_SRA = 6'b111000;
    localparam logic [5:0] FN_SRL = 6'b111001;
    localparam logic [5:0] FN_SLL = 6'b111010;
    localparam logic [5:0] FN_ROL = 6'b111100;
    localparam logic [5:0] FN_ROR = 6'b111101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    typedef enum logic [2:0] {
        RST, FETCH, DECODE, EXEC, MEM, WB, PCUPD
`ifdef CTRL_HALT_EN
        , HALT
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_B, CLS_HALT
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [3:0] alu_func;
        logic       bin_imm;
        logic       a_zero;
        logic       b_sel;
    } dec_t;

    function automatic logic fn_valid(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOT,
            FN_SRA, FN_SRL, FN_SLL, FN_ROL, FN_ROR: fn_valid = 1'b1;
            default:                                fn_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/func to instruction-class decoder; zero latency, no flow control.
// Opcode 111110 decodes to HALT only when CTRL_HALT_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec     = '0;
        dec.cls = CLS_NOP;
        case (opcode)
            OP_RTYPE: begin
                // Unlisted func codes fall through as NOP (no writeback, PC+4).
                if (fn_valid(func)) begin
                    dec.cls      = CLS_ALU;
                    dec.alu_func = func[3:0];
                end
            end
            OP_ADDI: begin
                dec.cls      = CLS_ALU;
                dec.alu_func = ALU_ADD;
                dec.bin_imm  = 1'b1;
            end
            OP_ANDI: begin
                dec.cls      = CLS_ALU;
                dec.alu_func = ALU_AND;
                dec.bin_imm  = 1'b1;
            end
            OP_ORI: begin
                dec.cls      = CLS_ALU;
                dec.alu_func = ALU_OR;
                dec.bin_imm  = 1'b1;
            end
            OP_LI, OP_LUI: begin
                dec.cls      = CLS_ALU;
                dec.alu_func = ALU_ADD;
                dec.bin_imm  = 1'b1;
                dec.a_zero   = 1'b1;
            end
            OP_BEQ: begin
                dec.cls      = CLS_BEQ;
                dec.alu_func = ALU_SUB;
                dec.b_sel    = 1'b1;
            end
            OP_BNE: begin
                dec.cls      = CLS_BNE;
                dec.alu_func = ALU_SUB;
                dec.b_sel    = 1'b1;
            end
            OP_LW: begin
                dec.cls      = CLS_LW;
                dec.alu_func = ALU_ADD;
                dec.bin_imm  = 1'b1;
            end
            OP_SW: begin
                dec.cls      = CLS_SW;
                dec.alu_func = ALU_ADD;
                dec.bin_imm  = 1'b1;
                dec.b_sel    = 1'b1;
            end
            OP_B: dec.cls = CLS_B;
`ifdef CTRL_HALT_EN
            OP_HALT: dec.cls = CLS_HALT;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle Moore control FSM with registered outputs; 3-6 cycles per instruction, no backpressure.
// Define CTRL_HALT_EN to make opcode 111110 park the FSM in HALT until Reset.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [31:0]         Instr,
    input  logic                Zero,
    output logic                dp_reset,
    output logic                pc_sel,
    output logic                pc_lden,
    output logic                rf_wren,
    output logic                rf_wrdata_sel,
    output logic                rf_b_sel,
    output logic                alu_bin_sel,
    output logic                alu_rf_a_sel,
    output logic [3:0]          alu_func,
    output logic                mem_wren,
    output logic [RETIRE_W-1:0] retired
);

    state_t              state_q, state_d;
    logic [5:0]          opcode_q, opcode_d, func_q, func_d;
    logic                zero_q, zero_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                dp_reset_q, dp_reset_d, pc_sel_q, pc_sel_d, pc_lden_q, pc_lden_d;
    logic                rf_wren_q, rf_wren_d, rf_wrdata_sel_q, rf_wrdata_sel_d;
    logic                rf_b_sel_q, rf_b_sel_d, alu_bin_sel_q, alu_bin_sel_d;
    logic                alu_rf_a_sel_q, alu_rf_a_sel_d, mem_wren_q, mem_wren_d;
    logic [3:0]          alu_func_q, alu_func_d;
    dec_t                dec_live, dec_lat, dec;

    ctrl_decode u_dec_live (.opcode(Instr[31:26]), .func(Instr[5:0]), .dec(dec_live));
    ctrl_decode u_dec_lat  (.opcode(opcode_q),     .func(func_q),     .dec(dec_lat));

    always_comb begin
        // The instruction word is live until DECODE closes; afterwards only the latched copy counts.
        dec       = (state_q == FETCH || state_q == DECODE) ? dec_live : dec_lat;
        opcode_d  = (state_q == DECODE) ? Instr[31:26] : opcode_q;
        func_d    = (state_q == DECODE) ? Instr[5:0]   : func_q;
        zero_d    = (state_q == EXEC)   ? Zero         : zero_q;
        retired_d = (state_q == PCUPD)  ? retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1} : retired_q;

        state_d = state_q;
        case (state_q)
            RST:    state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (dec.cls)
                    CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE: state_d = EXEC;
`ifdef CTRL_HALT_EN
                    CLS_HALT: state_d = HALT;
`endif
                    default: state_d = PCUPD;
                endcase
            end
            EXEC: begin
                case (dec.cls)
                    CLS_ALU:        state_d = WB;
                    CLS_LW, CLS_SW: state_d = MEM;
                    default:        state_d = PCUPD;
                endcase
            end
            MEM:    state_d = (dec.cls == CLS_LW) ? WB : PCUPD;
            WB:     state_d = PCUPD;
            PCUPD:  state_d = FETCH;
`ifdef CTRL_HALT_EN
            HALT:   state_d = HALT;
`endif
            default: state_d = RST;
        endcase

        // Outputs are a function of the state being entered, so they register alongside it.
        dp_reset_d      = (state_d == RST);
        pc_sel_d        = 1'b0;
        pc_lden_d       = 1'b0;
        rf_wren_d       = 1'b0;
        rf_wrdata_sel_d = 1'b0;
        rf_b_sel_d      = 1'b0;
        alu_bin_sel_d   = 1'b0;
        alu_rf_a_sel_d  = 1'b0;
        alu_func_d      = 4'b0000;
        mem_wren_d      = 1'b0;
        case (state_d)
            DECODE: rf_b_sel_d = dec.b_sel;
            EXEC: begin
                rf_b_sel_d     = dec.b_sel;
                alu_func_d     = dec.alu_func;
                alu_bin_sel_d  = dec.bin_imm;
                alu_rf_a_sel_d = dec.a_zero;
            end
            MEM: begin
                rf_b_sel_d = dec.b_sel;
                mem_wren_d = (dec.cls == CLS_SW);
            end
            WB: begin
                rf_b_sel_d      = dec.b_sel;
                rf_wren_d       = 1'b1;
                rf_wrdata_sel_d = (dec.cls == CLS_LW);
            end
            PCUPD: begin
                rf_b_sel_d = dec.b_sel;
                pc_lden_d  = 1'b1;
                pc_sel_d   = (dec.cls == CLS_B)
                           | ((dec.cls == CLS_BEQ) &  zero_d)
                           | ((dec.cls == CLS_BNE) & ~zero_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= RST;
            opcode_q        <= '0;
            func_q          <= '0;
            zero_q          <= 1'b0;
            retired_q       <= '0;
            dp_reset_q      <= 1'b1;
            pc_sel_q        <= 1'b0;
            pc_lden_q       <= 1'b0;
            rf_wren_q       <= 1'b0;
            rf_wrdata_sel_q <= 1'b0;
            rf_b_sel_q      <= 1'b0;
            alu_bin_sel_q   <= 1'b0;
            alu_rf_a_sel_q  <= 1'b0;
            alu_func_q      <= 4'b0000;
            mem_wren_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            func_q          <= func_d;
            zero_q          <= zero_d;
            retired_q       <= retired_d;
            dp_reset_q      <= dp_reset_d;
            pc_sel_q        <= pc_sel_d;
            pc_lden_q       <= pc_lden_d;
            rf_wren_q       <= rf_wren_d;
            rf_wrdata_sel_q <= rf_wrdata_sel_d;
            rf_b_sel_q      <= rf_b_sel_d;
            alu_bin_sel_q   <= alu_bin_sel_d;
            alu_rf_a_sel_q  <= alu_rf_a_sel_d;
            alu_func_q      <= alu_func_d;
            mem_wren_q      <= mem_wren_d;
        end
    end

    assign dp_reset      = dp_reset_q;
    assign pc_sel        = pc_sel_q;
    assign pc_lden       = pc_lden_q;
    assign rf_wren       = rf_wren_q;
    assign rf_wrdata_sel = rf_wrdata_sel_q;
    assign rf_b_sel      = rf_b_sel_q;
    assign alu_bin_sel   = alu_bin_sel_q;
    assign alu_rf_a_sel  = alu_rf_a_sel_q;
    assign alu_func      = alu_func_q;
    assign mem_wren      = mem_wren_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues expected per-instruction behaviour,
// a negedge monitor collects observations and compares at each pc_lden pulse.
module tb_multicycle_control;

    logic        Clk, Reset, Zero;
    logic [31:0] Instr;
    logic        dp_reset, pc_sel, pc_lden, rf_wren, rf_wrdata_sel, rf_b_sel;
    logic        alu_bin_sel, alu_rf_a_sel, mem_wren;
    logic [3:0]  alu_func;
    logic [15:0] retired;

    logic        s_dp_reset, s_pc_sel, s_pc_lden, s_rf_wren, s_rf_wrdata_sel, s_rf_b_sel;
    logic        s_alu_bin_sel, s_alu_rf_a_sel, s_mem_wren;
    logic [3:0]  s_alu_func;
    logic [2:0]  s_retired;

    multicycle_control #(.RETIRE_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
        .dp_reset(dp_reset), .pc_sel(pc_sel), .pc_lden(pc_lden), .rf_wren(rf_wren),
        .rf_wrdata_sel(rf_wrdata_sel), .rf_b_sel(rf_b_sel), .alu_bin_sel(alu_bin_sel),
        .alu_rf_a_sel(alu_rf_a_sel), .alu_func(alu_func), .mem_wren(mem_wren),
        .retired(retired)
    );

    // Narrow counter instance so the all-ones -> 0 wrap is reachable in a short run.
    multicycle_control #(.RETIRE_W(3)) dut_s (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
        .dp_reset(s_dp_reset), .pc_sel(s_pc_sel), .pc_lden(s_pc_lden), .rf_wren(s_rf_wren),
        .rf_wrdata_sel(s_rf_wrdata_sel), .rf_b_sel(s_rf_b_sel), .alu_bin_sel(s_alu_bin_sel),
        .alu_rf_a_sel(s_alu_rf_a_sel), .alu_func(s_alu_func), .mem_wren(s_mem_wren),
        .retired(s_retired)
    );

    typedef struct {
        string     name;
        int        cycles;
        bit        psel;
        bit [7:0]  wbm;
        bit [7:0]  memm;
        bit        wrs;
        bit [3:0]  fn;
        bit        bn;
        bit        az;
        bit        bs;
        bit [15:0] ret;
        bit [2:0]  ret_s;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_ret = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor state, owned by the monitor process only.
    int       m_cyc, m_stray;
    bit [7:0] m_wbm, m_memm;
    bit       m_wrs, m_bs, m_bn, m_az;
    bit [3:0] m_fn;
    exp_t     m_e;

    task automatic m_clear();
        m_cyc = 0; m_stray = 0; m_wbm = '0; m_memm = '0;
        m_wrs = 0; m_bs = 0; m_bn = 0; m_az = 0; m_fn = '0;
    endtask

    always @(negedge Clk) begin
        if (!Reset || dp_reset) begin
            m_clear();
        end else begin
            m_cyc++;
            if (m_cyc < 8) begin
                if (rf_wren)  m_wbm[m_cyc]  = 1'b1;
                if (mem_wren) m_memm[m_cyc] = 1'b1;
            end
            if (rf_wrdata_sel) m_wrs = 1'b1;
            if (rf_b_sel)      m_bs  = 1'b1;
            if (m_cyc == 3) begin
                m_fn = alu_func; m_bn = alu_bin_sel; m_az = alu_rf_a_sel;
            end else if (alu_func != 4'b0 || alu_bin_sel || alu_rf_a_sel) begin
                m_stray++;
            end
            if (pc_lden) begin
                if (q.size() == 0) begin
                    chk("unexpected pc_lden", 32'd1, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk({m_e.name, " cycles"},        m_cyc,     m_e.cycles);
                    chk({m_e.name, " pc_sel"},        pc_sel,    m_e.psel);
                    chk({m_e.name, " rf_wren cyc"},   m_wbm,     m_e.wbm);
                    chk({m_e.name, " mem_wren cyc"},  m_memm,    m_e.memm);
                    chk({m_e.name, " rf_wrdata_sel"}, m_wrs,     m_e.wrs);
                    chk({m_e.name, " alu_func"},      m_fn,      m_e.fn);
                    chk({m_e.name, " alu_bin_sel"},   m_bn,      m_e.bn);
                    chk({m_e.name, " alu_rf_a_sel"},  m_az,      m_e.az);
                    chk({m_e.name, " rf_b_sel"},      m_bs,      m_e.bs);
                    chk({m_e.name, " alu stray"},     m_stray,   0);
                    chk({m_e.name, " retired"},       retired,   m_e.ret);
                    chk({m_e.name, " retired_w3"},    s_retired, m_e.ret_s);
                end
                m_clear();
            end
        end
    end

    // Called in a FETCH cycle; returns on the edge that starts the next FETCH.
    task automatic run(input string nm, input logic [31:0] ins, input bit z, input int cyc,
                       input bit psel, input bit [7:0] wbm, input bit [7:0] memm, input bit wrs,
                       input bit [3:0] fn, input bit bn, input bit az, input bit bs);
        exp_t e;
        #1;
        Instr = ins;
        Zero  = z;
        e.name = nm; e.cycles = cyc; e.psel = psel; e.wbm = wbm; e.memm = memm;
        e.wrs = wrs; e.fn = fn; e.bn = bn; e.az = az; e.bs = bs;
        e.ret = n_ret[15:0]; e.ret_s = n_ret[2:0];
        q.push_back(e);
        repeat (cyc) @(posedge Clk);
        n_ret++;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset dp_reset", dp_reset, 1'b1);
        chk("reset outputs", {pc_sel, pc_lden, rf_wren, rf_wrdata_sel, rf_b_sel,
                              alu_bin_sel, alu_rf_a_sel, alu_func, mem_wren}, 0);
        chk("reset retired", retired, 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("fetch dp_reset", dp_reset, 1'b0);
        chk("fetch retired", retired, 0);
        n_ret = 0;
    endtask

    initial begin
        Reset = 1'b0;
        Instr = '0;
        Zero  = 1'b0;
        do_reset();

        //   name        instr          Z  cyc psel wb     mem    wrs fn    bn az bs
        run("add",      32'h80231030, 0, 5, 0, 8'h10, 8'h00, 0, 4'h0, 0, 0, 0);
        run("beq z1",   32'h00000004, 1, 4, 1, 8'h00, 8'h00, 0, 4'h1, 0, 0, 1);
        run("beq z0",   32'h00000004, 0, 4, 0, 8'h00, 8'h00, 0, 4'h1, 0, 0, 1);
        run("sw",       32'h7C000000, 0, 5, 0, 8'h00, 8'h10, 0, 4'h0, 1, 0, 1);
        run("lw",       32'h3C000000, 0, 6, 0, 8'h20, 8'h00, 1, 4'h0, 1, 0, 0);
        run("sub",      32'h80000031, 0, 5, 0, 8'h10, 8'h00, 0, 4'h1, 0, 0, 0);
        run("ror",      32'h8000003D, 0, 5, 0, 8'h10, 8'h00, 0, 4'hD, 0, 0, 0);
        run("andi",     32'hC8000000, 0, 5, 0, 8'h10, 8'h00, 0, 4'h2, 1, 0, 0);
        run("ori",      32'hCC000000, 0, 5, 0, 8'h10, 8'h00, 0, 4'h3, 1, 0, 0);
        run("li",       32'hE0000000, 0, 5, 0, 8'h10, 8'h00, 0, 4'h0, 1, 1, 0);
        run("lui",      32'hE4000000, 0, 5, 0, 8'h10, 8'h00, 0, 4'h0, 1, 1, 0);
        run("bne z0",   32'h04000000, 0, 4, 1, 8'h00, 8'h00, 0, 4'h1, 0, 0, 1);
        run("bne z1",   32'h04000000, 1, 4, 0, 8'h00, 8'h00, 0, 4'h1, 0, 0, 1);
        run("b",        32'hFC000000, 1, 3, 1, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0);
        run("rnop f00", 32'h80000000, 0, 3, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0);
        run("rnop f3b", 32'h8000003B, 0, 3, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0);
        run("unk op",   32'h08000000, 0, 3, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0);
`ifndef CTRL_HALT_EN
        run("op3e nop", 32'hF8000000, 0, 3, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0);
`endif

        for (int i = 0; i < 8 && (n_ret % 8) != 7; i++)
            run("pad nop", 32'h08000000, 0, 3, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0);
        #1;
        chk("w3 at all-ones", s_retired, 3'd7);
        run("wrap nop", 32'h08000000, 0, 3, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0);
        #1;
        chk("w3 wrapped", s_retired, 3'd0);
        chk("w16 count", retired, n_ret[15:0]);
        @(negedge Clk);
        chk("queue drained", q.size(), 0);

`ifdef CTRL_HALT_EN
        begin
            int bad;
            bad = 0;
            @(posedge Clk);
            #1;
            Instr = 32'hF8000000;
            repeat (2) @(posedge Clk);
            repeat (100) begin
                @(negedge Clk);
                if (pc_lden || rf_wren || mem_wren || pc_sel || rf_b_sel || alu_func != 4'b0)
                    bad++;
            end
            chk("halt enables", bad, 0);
            chk("halt retired", retired, n_ret[15:0]);
        end
`endif

        do_reset();
        #1;
        Instr = 32'h7C000000;
        Zero  = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        chk("sw mem_wren in MEM", mem_wren, 1'b1);
        Reset = 1'b0;
        #1;
        chk("async mem_wren", mem_wren, 1'b0);
        chk("async enables", {pc_lden, rf_wren, rf_b_sel}, 0);
        chk("async dp_reset", dp_reset, 1'b1);
        repeat (2) @(posedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
